// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the pipelined MIPS CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register with flush > hold > load priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // A flush always produces a bubble, even if the stage also asked to hold.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_load && !i_hold) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch: PC, imem address, IF/ID fill, halt detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic [7:0]  fetch_count_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [7:0]   r_cnt;
    logic [7:0]   w_cnt_nxt;
    logic         r_halted;
    logic         w_halted_nxt;
    logic         w_flush;
    logic         w_hold;
    logic         w_load;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redirect_pc;
    logic         w_unused_lsb;

    assign w_pc_plus4    = r_pc + PC_STEP;
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
    // Misaligned redirect targets are silently truncated to a word boundary.
    assign w_unused_lsb  = ^redirect_pc_i[1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_cnt    <= 8'd0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_cnt_nxt    = r_cnt;
        w_halted_nxt = r_halted;
        w_flush      = 1'b0;
        w_hold       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_flush     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    w_pc_nxt = w_redirect_pc;
                    w_flush  = 1'b1;
                end else if (stall_i) begin
                    w_hold = 1'b1;
                end else if (imem_rdata_i == HALT_WORD) begin
                    // The halt word is consumed here and never reaches decode.
                    w_flush      = 1'b1;
                    w_halted_nxt = 1'b1;
                    w_state_nxt  = ST_HALTED;
                end else begin
                    w_pc_nxt  = w_pc_plus4;
                    w_load    = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_HALTED: begin
                w_flush = 1'b1;
                if (redirect_i) begin
                    w_pc_nxt     = w_redirect_pc;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = ST_RUN;
                end
            end
            default: begin
                w_flush     = 1'b1;
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk     (CLK),
        .rst     (RST),
        .i_flush (w_flush),
        .i_hold  (w_hold),
        .i_load  (w_load),
        .i_instr (imem_rdata_i),
        .i_pc4   (w_pc_plus4),
        .o_instr (ifid_instr_o),
        .o_pc4   (ifid_pc4_o),
        .o_valid (ifid_valid_o)
    );

    assign imem_addr_o   = r_pc;
    assign halted_o      = r_halted;
    assign fetch_count_o = r_cnt;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_halt     = 32'hFFFF_FFFF;
    localparam int          c_m_boot   = 0;
    localparam int          c_m_run    = 1;
    localparam int          c_m_halt   = 2;

    logic        CLK;
    logic        RST;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic [7:0]  fetch_count_o;

    logic [31:0] mem [256];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_halted;
    logic [7:0]  m_cnt;
    int          m_mode;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage #(
        .RESET_PC  (c_reset_pc),
        .HALT_WORD (c_halt)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o),
        .fetch_count_o (fetch_count_o)
    );

    always #5 CLK = ~CLK;

    // Low 1 KiB comes from the table; everything above is a fixed non-halt hash.
    function automatic logic [31:0] mem_at(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        if (a < 32'h400) return mem[idx];
        return a ^ 32'h5A5A_0000;
    endfunction

    always_comb imem_rdata_i = mem_at(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    task automatic compare_all();
        check("imem_addr",  imem_addr_o,           m_pc);
        check("ifid_instr", ifid_instr_o,          m_instr);
        check("ifid_pc4",   ifid_pc4_o,            m_pc4);
        check("ifid_valid", 32'(ifid_valid_o),     32'(m_valid));
        check("halted",     32'(halted_o),         32'(m_halted));
        check("fetch_cnt",  32'(fetch_count_o),    32'(m_cnt));
    endtask

    // One clock: predict from the rules, apply the edge, compare everything.
    task automatic step(input bit rst, input bit stall, input bit redir, input logic [31:0] tgt);
        logic [31:0] word;
        RST = rst; stall_i = stall; redirect_i = redir; redirect_pc_i = tgt;
        word = mem_at(m_pc);
        if (rst) begin
            m_pc = c_reset_pc; m_instr = 0; m_pc4 = 0; m_valid = 0;
            m_halted = 0; m_cnt = 0; m_mode = c_m_boot;
        end else if (m_mode == c_m_boot) begin
            m_mode = c_m_run;
        end else if (m_mode == c_m_halt) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (redir) begin
                m_pc = tgt & ~32'd3; m_halted = 0; m_mode = c_m_run;
            end
        end else if (redir) begin
            m_pc = tgt & ~32'd3; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (!stall) begin
            if (word == c_halt) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 1; m_mode = c_m_halt;
            end else begin
                m_instr = word; m_pc = m_pc + 32'd4; m_pc4 = m_pc;
                m_valid = 1; m_cnt = m_cnt + 8'd1;
            end
        end
        @(posedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    initial begin
        int guard;
        CLK = 0; RST = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
        m_mode = c_m_boot;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i] == c_halt) mem[i] = 32'h1234_5678;
        end
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h010A_5020;
        mem[4] = c_halt;
        mem[40] = c_halt;
        mem[100] = c_halt;
        @(negedge CLK);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 1, 32'h100);
        check("boot_valid", 32'(ifid_valid_o), 32'd0);
        check("boot_pc", imem_addr_o, 32'h0);
        step(0, 0, 0, 0);
        check("w0_instr", ifid_instr_o, 32'h2008_0001);
        check("w0_pc4", ifid_pc4_o, 32'h4);
        step(0, 0, 0, 0);
        check("w1_instr", ifid_instr_o, 32'h2009_0002);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0);
            check("stall_addr", imem_addr_o, 32'h8);
            check("stall_instr", ifid_instr_o, 32'h2009_0002);
            check("stall_cnt", 32'(fetch_count_o), 32'd2);
        end
        step(0, 0, 0, 0);
        check("w2_instr", ifid_instr_o, 32'h010A_5020);
        check("w2_pc4", ifid_pc4_o, 32'hC);
        check("w2_cnt", 32'(fetch_count_o), 32'd3);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("halt_flag", 32'(halted_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, i[0], 0, 0);
            check("halt_pc", imem_addr_o, 32'h10);
            check("halt_cnt", 32'(fetch_count_o), 32'd4);
        end
        step(0, 0, 1, 32'h20);
        check("unhalt", 32'(halted_o), 32'd0);
        step(0, 0, 0, 0);
        check("resume_pc4", ifid_pc4_o, 32'h24);
        step(0, 1, 1, 32'h43);
        check("redir_pc", imem_addr_o, 32'h40);
        check("redir_valid", 32'(ifid_valid_o), 32'd0);
        step(0, 0, 0, 0);
        check("redir_pc4", ifid_pc4_o, 32'h44);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check("pc_wrap", imem_addr_o, 32'h0);

        // Counter wrap, fetching from the hashed region with random stalls.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h1000);
        guard = 0;
        while (m_cnt != 8'd255 && guard < 2000) begin
            step(0, $urandom_range(0, 3) == 0, 0, 0);
            guard++;
        end
        check("cnt_reached", 32'(m_cnt), 32'd255);
        step(0, 0, 0, 0);
        check("cnt_wrap", 32'(fetch_count_o), 32'd0);

        // Reset while halted, then reset while stalled.
        step(0, 0, 1, 32'hC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("pre_rst_halt", 32'(halted_o), 32'd1);
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h80);
        check("boot_ignores", imem_addr_o, 32'h0);
        step(0, 0, 0, 0);
        check("post_rst_w0", ifid_instr_o, 32'h2008_0001);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("post_rst2_w0", ifid_instr_o, 32'h2008_0001);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 32'h3FF) : $urandom;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, tgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS CPU: owns the PC, drives the instruction-memory address, and fills the IF/ID pipeline register consumed by decode.
- Accepts stall from the hazard unit and branch/jump redirects from later stages.
- Recognises a terminator word so simulation runs end cleanly.
- Sits between the CPU top-level clock/reset and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
stall_i  in  1  hazard unit: hold PC and IF/ID
redirect_i  in  1  taken branch/jump: flush IF/ID, load new PC
redirect_pc_i  in  32  redirect target
imem_addr_o  out  32  instruction memory byte address (= PC register, combinational)
imem_rdata_i  in  32  instruction word at imem_addr_o, combinational read, same cycle
ifid_instr_o  out  32  IF/ID instruction
ifid_pc4_o  out  32  IF/ID PC+4 of that instruction
ifid_valid_o  out  1  IF/ID holds a real instruction
halted_o  out  1  fetch stopped on HALT_WORD
fetch_count_o  out  8  count of instructions delivered to IF/ID

Behaviour:
- Reset (RST=1 at rising edge, any state):
  - pc = RESET_PC, ifid_instr_o = 32'h0 (NOP, sll $0), ifid_pc4_o = 0, ifid_valid_o = 0.
  - halted_o = 0, fetch_count_o = 0, state = BOOT.
  - Reset mid-operation discards all in-flight state identically.
- BOOT (exactly one cycle after RST deasserts):
  - PC held, IF/ID stays NOP/valid 0.
  - Unconditionally -> RUN; stall and redirect are ignored.
- RUN, evaluated per edge with priority redirect > stall > halt detect > normal:
  - redirect_i=1: pc <= {redirect_pc_i[31:2],2'b00}; IF/ID <= NOP, valid 0, pc4 0; count unchanged. A redirect in the same cycle as stall wins and clears the stall effect.
  - stall_i=1: pc, IF/ID and count all hold.
  - imem_rdata_i == HALT_WORD: pc holds; IF/ID <= NOP, valid 0; halted_o <= 1; -> HALTED. The halt word is never delivered.
  - normal: pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); ifid_instr_o <= imem_rdata_i; ifid_pc4_o <= pc+4; ifid_valid_o <= 1; fetch_count_o <= fetch_count_o+1 (wraps 255 -> 0).
- HALTED:
  - PC frozen; IF/ID forced to NOP, valid 0; stall ignored.
  - redirect_i=1 (an older branch squashing a speculatively fetched halt): pc <= aligned target; halted_o <= 0; -> RUN.
  - Only RST or redirect leaves HALTED.
- Timing:
  - Latency PC -> IF/ID is one cycle.
  - imem_addr_o changes only after a clock edge.
  - All outputs are registered except imem_addr_o, which is a direct copy of the pc register.
- Redirect target bits [1:0] are silently dropped; no misalignment flag.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR = 32'h0
  - PC_STEP = 32'd4
  - default HALT_WORD
  - fetch state enum {BOOT, RUN, HALTED}, 2-bit encoding
- Sub-module ifid_reg (IF/ID pipeline register with hold/flush/load controls, instr + pc4 + valid). It is reused as a pattern by later pipeline registers.
- PC logic and the FSM stay in fetch_stage.

Test Plan:
- Reset then free-run over memory holding 0x20080001, 0x20090002, 0x010A5020 at 0,4,8:
  - BOOT cycle shows valid 0.
  - Following edges deliver those words with pc4 = 4, 8, 12.
  - fetch_count_o reaches 3.
- stall_i high 2 cycles while PC = 0x8: imem_addr_o stays 0x8 and IF/ID and count are unchanged for both cycles. On release, the word at 0x8 is delivered with pc4 = 0xC.
- redirect_i and stall_i together with redirect_pc_i = 0x0000_0043:
  - next pc = 0x40, IF/ID = NOP, valid 0.
  - following edge delivers the word at 0x40 with pc4 = 0x44.
- HALT_WORD at 0x10:
  - after the word at 0xC, halted_o = 1, PC stuck at 0x10, valid 0, count frozen, with stall toggling.
  - redirect to 0x20 clears halted_o and resumes at 0x20.
- Wrap cases:
  - PC preset via redirect to 0xFFFF_FFFC: next pc = 0x0.
  - count preloaded by 255 deliveries: count wraps to 0 on the 256th.
- RST asserted mid-stream while HALTED and while stalled: all outputs return to their reset values on the next edge, and one BOOT cycle precedes fetch resuming at RESET_PC.
